// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: RAW detection against EXE/MEM, branch flush sequencing,
// multi-cycle-op wait with timeout, and saturating stall/flush counters.
module hazard_ctrl_unit #(
  parameter int unsigned REG_ADDR_W   = 4,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MC_TIMEOUT   = 64,
  parameter int unsigned CNT_W        = 16,
  parameter bit          R0_HARDWIRED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  forward_en,
  input  logic [REG_ADDR_W-1:0] src1_id,
  input  logic [REG_ADDR_W-1:0] src2_id,
  input  logic                  src2_valid,
  input  logic [REG_ADDR_W-1:0] dest_exe,
  input  logic                  wb_en_exe,
  input  logic                  mem_r_en_exe,
  input  logic [REG_ADDR_W-1:0] dest_mem,
  input  logic                  wb_en_mem,
  input  logic                  branch_taken,
  input  logic                  mc_start,
  input  logic                  mc_done,
  output logic                  pc_freeze,
  output logic                  if_id_freeze,
  output logic                  id_ex_bubble,
  output logic                  flush,
  output logic                  hazard_detected,
  output logic                  mc_timeout,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int unsigned FcW = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned TcW = $clog2(MC_TIMEOUT + 1);
  localparam logic [FcW-1:0] FcReload = FcW'(FLUSH_CYCLES - 1);
  // Last MCWAIT cycle before forced release; the mc_start cycle makes the stall MC_TIMEOUT long.
  localparam logic [TcW-1:0] TcLast = TcW'(MC_TIMEOUT - 2);

  typedef enum logic [1:0] {StRun, StFlush, StMcwait} state_e;

  state_e         state_q, state_d;
  logic [FcW-1:0] fcnt_q, fcnt_d;
  logic [TcW-1:0] tcnt_q, tcnt_d;
  logic           timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic exe_hz, mem_hz, load_use, hz;
  logic freeze_c, bubble_c, flush_c;

  function automatic logic match(input logic [REG_ADDR_W-1:0] src,
                                 input logic [REG_ADDR_W-1:0] dst);
    return (src == dst) && !(R0_HARDWIRED && (src == '0));
  endfunction

  always_comb begin
    exe_hz   = wb_en_exe & (match(src1_id, dest_exe) | (src2_valid & match(src2_id, dest_exe)));
    mem_hz   = wb_en_mem & (match(src1_id, dest_mem) | (src2_valid & match(src2_id, dest_mem)));
    load_use = mem_r_en_exe & exe_hz;
    hz       = forward_en ? load_use : (exe_hz | mem_hz);
  end

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    tcnt_d    = tcnt_q;
    timeout_d = 1'b0;
    freeze_c  = 1'b0;
    bubble_c  = 1'b0;
    flush_c   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (branch_taken) begin
          flush_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = StFlush;
            fcnt_d  = FcReload;
          end
        end else if (mc_start) begin
          freeze_c = 1'b1;
          state_d  = StMcwait;
          tcnt_d   = '0;
        end else if (hz) begin
          freeze_c = 1'b1;
          bubble_c = 1'b1;
        end
      end
      StFlush: begin
        flush_c = 1'b1;
        if (branch_taken) begin
          fcnt_d = FcReload;
        end else if (fcnt_q == FcW'(1)) begin
          state_d = StRun;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - FcW'(1);
        end
      end
      StMcwait: begin
        freeze_c = 1'b1;
        tcnt_d   = tcnt_q + TcW'(1);
        if (mc_done) begin
          state_d = StRun;
        end else if (tcnt_q == TcLast) begin
          state_d   = StRun;
          timeout_d = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Combinational outputs are held low while reset is asserted.
  always_comb begin
    pc_freeze       = rst & freeze_c;
    if_id_freeze    = rst & freeze_c;
    id_ex_bubble    = rst & bubble_c;
    flush           = rst & flush_c;
    hazard_detected = rst & hz;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StRun;
      fcnt_q      <= '0;
      tcnt_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
      if (pc_freeze && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign mc_timeout = timeout_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: vector table for hazard detection plus
// hand-written flush, multi-cycle wait, timeout, saturation and reset sequences.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       forward_en, src2_valid, wb_en_exe, mem_r_en_exe, wb_en_mem;
  logic       branch_taken, mc_start, mc_done;
  logic [3:0] src1_id, src2_id, dest_exe, dest_mem;
  logic       pc_freeze, if_id_freeze, id_ex_bubble, flush, hazard_detected, mc_timeout;
  logic [3:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  hazard_ctrl_unit #(
    .REG_ADDR_W  (4),
    .FLUSH_CYCLES(2),
    .MC_TIMEOUT  (8),
    .CNT_W       (4),
    .R0_HARDWIRED(1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .forward_en     (forward_en),
    .src1_id        (src1_id),
    .src2_id        (src2_id),
    .src2_valid     (src2_valid),
    .dest_exe       (dest_exe),
    .wb_en_exe      (wb_en_exe),
    .mem_r_en_exe   (mem_r_en_exe),
    .dest_mem       (dest_mem),
    .wb_en_mem      (wb_en_mem),
    .branch_taken   (branch_taken),
    .mc_start       (mc_start),
    .mc_done        (mc_done),
    .pc_freeze      (pc_freeze),
    .if_id_freeze   (if_id_freeze),
    .id_ex_bubble   (id_ex_bubble),
    .flush          (flush),
    .hazard_detected(hazard_detected),
    .mc_timeout     (mc_timeout),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fwd;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       s2v;
    logic [3:0] de;
    logic       we;
    logic       mre;
    logic [3:0] dm;
    logic       wm;
    logic       hz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic idle();
    forward_en = 1'b0; src1_id = 4'd0; src2_id = 4'd0; src2_valid = 1'b0;
    dest_exe = 4'd0; wb_en_exe = 1'b0; mem_r_en_exe = 1'b0;
    dest_mem = 4'd0; wb_en_mem = 1'b0;
    branch_taken = 1'b0; mc_start = 1'b0; mc_done = 1'b0;
  endtask

  // Non-forwarding EXE hazard on r3.
  task automatic set_hazard();
    forward_en = 1'b0; src1_id = 4'd3; dest_exe = 4'd3; wb_en_exe = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic chk_ctl(input string name, input logic frz, input logic bub, input logic fl);
    chk1({name, ".pc_freeze"}, pc_freeze, frz);
    chk1({name, ".if_id_freeze"}, if_id_freeze, frz);
    chk1({name, ".id_ex_bubble"}, id_ex_bubble, bub);
    chk1({name, ".flush"}, flush, fl);
  endtask

  initial begin
    //            fwd   s1     s2     s2v   de     we    mre   dm     wm    hz
    vecs[0]  = '{1'b1, 4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'd1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'd1, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'd7, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 4'd7, 4'd0, 1'b0, 4'd7, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 4'd5, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 4'd2, 4'd6, 1'b1, 4'd6, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 4'd2, 4'd6, 1'b0, 4'd6, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 4'd9, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd9, 1'b1, 1'b1};

    idle();
    #2;
    chk_ctl("por", 1'b0, 1'b0, 1'b0);
    chkn("por.stall_cnt", stall_cnt, 4'd0);
    chk1("por.mc_timeout", mc_timeout, 1'b0);
    do_reset();

    // Hazard detection table, all in the run state.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      idle();
      forward_en = vecs[i].fwd; src1_id = vecs[i].s1; src2_id = vecs[i].s2;
      src2_valid = vecs[i].s2v; dest_exe = vecs[i].de; wb_en_exe = vecs[i].we;
      mem_r_en_exe = vecs[i].mre; dest_mem = vecs[i].dm; wb_en_mem = vecs[i].wm;
      #2;
      chk1($sformatf("vec%0d.hazard_detected", i), hazard_detected, vecs[i].hz);
      chk_ctl($sformatf("vec%0d", i), vecs[i].hz, vecs[i].hz, 1'b0);
    end

    // Branch wins over a present hazard and flushes for two cycles.
    do_reset();
    @(negedge clk); set_hazard(); branch_taken = 1'b1; #2;
    chk_ctl("br.c0", 1'b0, 1'b0, 1'b1);
    chk1("br.c0.hazard_detected", hazard_detected, 1'b1);
    @(negedge clk); branch_taken = 1'b0; #2;
    chk_ctl("br.c1", 1'b0, 1'b0, 1'b1);
    @(negedge clk); idle(); #2;
    chk_ctl("br.c2", 1'b0, 1'b0, 1'b0);
    chkn("br.flush_cnt", flush_cnt, 4'd2);
    chkn("br.stall_cnt", stall_cnt, 4'd0);

    // A second branch during the flush reloads the flush count.
    @(negedge clk); branch_taken = 1'b1; #2;
    chk1("brr.c0.flush", flush, 1'b1);
    @(negedge clk); mc_start = 1'b1; #2;
    chk_ctl("brr.c1", 1'b0, 1'b0, 1'b1);
    @(negedge clk); idle(); #2;
    chk_ctl("brr.c2", 1'b0, 1'b0, 1'b1);
    @(negedge clk); #2;
    chk_ctl("brr.c3", 1'b0, 1'b0, 1'b0);
    chkn("brr.flush_cnt", flush_cnt, 4'd5);

    // Multi-cycle op completing after 5 cycles: 6 freeze cycles, no bubble.
    do_reset();
    @(negedge clk); mc_start = 1'b1; #2;
    chk_ctl("mc.c0", 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      idle();
      set_hazard();
      branch_taken = (c == 2);
      mc_done = (c == 5);
      #2;
      chk_ctl($sformatf("mc.c%0d", c), 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk); idle(); #2;
    chk_ctl("mc.c6", 1'b0, 1'b0, 1'b0);
    chkn("mc.stall_cnt", stall_cnt, 4'd6);
    chkn("mc.flush_cnt", flush_cnt, 4'd0);
    chk1("mc.mc_timeout", mc_timeout, 1'b0);

    // No mc_done: forced release after 8 freeze cycles, registered pulse follows.
    do_reset();
    @(negedge clk); mc_start = 1'b1; #2;
    chk_ctl("to.c0", 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk); idle(); #2;
      chk_ctl($sformatf("to.c%0d", c), 1'b1, 1'b0, 1'b0);
      chk1($sformatf("to.c%0d.mc_timeout", c), mc_timeout, 1'b0);
    end
    @(negedge clk); #2;
    chk_ctl("to.c8", 1'b0, 1'b0, 1'b0);
    chk1("to.c8.mc_timeout", mc_timeout, 1'b1);
    chkn("to.stall_cnt", stall_cnt, 4'd8);
    @(negedge clk); #2;
    chk1("to.c9.mc_timeout", mc_timeout, 1'b0);

    // Held hazard for 20 cycles saturates the 4-bit stall counter.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); set_hazard(); #2;
      chk1($sformatf("sat.c%0d.pc_freeze", c), pc_freeze, 1'b1);
    end
    @(negedge clk); idle(); #2;
    chkn("sat.stall_cnt", stall_cnt, 4'd15);

    // Asynchronous reset in the middle of a wait with inputs active.
    do_reset();
    @(negedge clk); mc_start = 1'b1; #2;
    @(negedge clk); mc_start = 1'b0; set_hazard(); branch_taken = 1'b1; #2;
    chk1("rst.pre.pc_freeze", pc_freeze, 1'b1);
    rst = 1'b0;
    #1;
    chk_ctl("rst.active", 1'b0, 1'b0, 1'b0);
    chk1("rst.active.hazard_detected", hazard_detected, 1'b0);
    chkn("rst.active.stall_cnt", stall_cnt, 4'd0);
    chk1("rst.active.mc_timeout", mc_timeout, 1'b0);
    @(negedge clk); idle(); rst = 1'b1; #2;
    chk_ctl("rst.after", 1'b0, 1'b0, 1'b0);
    chkn("rst.after.stall_cnt", stall_cnt, 4'd0);
    chkn("rst.after.flush_cnt", flush_cnt, 4'd0);
    @(negedge clk); set_hazard(); #2;
    chk_ctl("rst.run", 1'b1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
